// File: rtl/cci_mpf_prim_semaphore_sched_pkg.sv
// cci_mpf_prim_semaphore_sched_pkg: shared types and constants for the semaphore scheduler
package cci_mpf_prim_semaphore_sched_pkg;
    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} t_sched_state;
    localparam int STAT_CNT_W = 32;
    function automatic int cnt_w(input int n_entries);
        return $clog2(n_entries) + 1;
    endfunction
    localparam int DEFAULT_N_ENTRIES = 16;
    typedef logic [cnt_w(DEFAULT_N_ENTRIES)-1:0] t_count;
endpackage

// File: rtl/cci_mpf_prim_semaphore_sched_if.sv
// cci_mpf_prim_semaphore_sched_if: request, completion and flush handshake bundle
interface cci_mpf_prim_semaphore_sched_if #(
    parameter int N_VALUE_BITS = 10
);
    logic req_valid;
    logic [N_VALUE_BITS-1:0] req_value;
    logic req_ready;
    logic cmpl_en;
    logic [N_VALUE_BITS-1:0] cmpl_value;
    logic flush_req;
    logic flush_done;
    modport master (
        output req_valid, req_value, cmpl_en, flush_req,
        input  req_ready, cmpl_value, flush_done
    );
    modport slave (
        input  req_valid, req_value, cmpl_en, flush_req,
        output req_ready, cmpl_value, flush_done
    );
endinterface

// File: rtl/cci_mpf_prim_semaphore_cam.sv
// cci_mpf_prim_semaphore_cam: round-robin semaphore CAM, set and clear slots in allocation order
module cci_mpf_prim_semaphore_cam #(
    parameter int N_ENTRIES = 16,
    parameter int N_VALUE_BITS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic set_en,
    input  logic [N_VALUE_BITS-1:0] set_value,
    input  logic clr_en,
    input  logic [N_VALUE_BITS-1:0] test_value,
    output logic hit
);
    localparam int IW = $clog2(N_ENTRIES);
    logic [N_VALUE_BITS-1:0] vals [N_ENTRIES];
    logic [N_ENTRIES-1:0] valid;
    logic [IW-1:0] set_idx;
    logic [IW-1:0] clr_idx;
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            set_idx <= '0;
            clr_idx <= '0;
        end else begin
            if (set_en) begin
                vals[set_idx] <= set_value;
                valid[set_idx] <= 1'b1;
                set_idx <= set_idx + 1'b1;
            end
            if (clr_en) begin
                valid[clr_idx] <= 1'b0;
                clr_idx <= clr_idx + 1'b1;
            end
        end
    end
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < N_ENTRIES; i++)
            hit = hit | (valid[i] && vals[i] == test_value);
    end
endmodule

// File: rtl/cci_mpf_prim_semaphore_sched_fifo.sv
// cci_mpf_prim_semaphore_sched_fifo: in-order ring buffer of in-flight tag values
module cci_mpf_prim_semaphore_sched_fifo
    import cci_mpf_prim_semaphore_sched_pkg::*;
#(
    parameter int N_ENTRIES = 16,
    parameter int N_VALUE_BITS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic [N_VALUE_BITS-1:0] push_value,
    input  logic pop,
    output logic [N_VALUE_BITS-1:0] head,
    output logic [cnt_w(N_ENTRIES)-1:0] count
);
    localparam int IW = $clog2(N_ENTRIES);
    localparam int CW = cnt_w(N_ENTRIES);
    logic [N_VALUE_BITS-1:0] mem [N_ENTRIES];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr_idx] <= push_value;
                wr_idx <= wr_idx + 1'b1;
            end
            if (pop) rd_idx <= rd_idx + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assign head = mem[rd_idx];
endmodule

// File: rtl/cci_mpf_prim_semaphore_sched.sv
// cci_mpf_prim_semaphore_sched: tag-conflict issue scheduler; CCI_MPF_SEMAPHORE_SCHED_STATS_EN builds the stall counter
module cci_mpf_prim_semaphore_sched
    import cci_mpf_prim_semaphore_sched_pkg::*;
#(
    parameter int N_ENTRIES = 16,
    parameter int N_VALUE_BITS = 10
) (
    input  logic clk,
    input  logic reset,
    cci_mpf_prim_semaphore_sched_if.slave sched,
    output logic rdy,
    output logic conflict_stall,
    output logic [cnt_w(N_ENTRIES)-1:0] n_inflight,
    output logic err_underflow,
    output logic [STAT_CNT_W-1:0] stat_conflict_cycles
);
    localparam int CW = cnt_w(N_ENTRIES);
    t_sched_state state;
    t_sched_state state_nxt;
    logic hit;
    logic can_issue;
    logic grant;
    logic pop;
    assign can_issue = rdy && state == RUN && n_inflight != CW'(N_ENTRIES);
    assign sched.req_ready = can_issue && !hit;
    assign grant = sched.req_valid && sched.req_ready;
    assign pop = sched.cmpl_en && n_inflight != '0;
    assign conflict_stall = sched.req_valid && can_issue && hit;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            rdy <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy <= 1'b1;
            err_underflow <= err_underflow | (sched.cmpl_en && n_inflight == '0);
        end
    end
    always_comb begin
        state_nxt = (state == RUN) ? (sched.flush_req ? DRAIN : RUN) : (n_inflight == '0 ? RUN : DRAIN);
        sched.flush_done = state == DRAIN && n_inflight == '0;
    end
    cci_mpf_prim_semaphore_cam #(
        .N_ENTRIES(N_ENTRIES),
        .N_VALUE_BITS(N_VALUE_BITS)
    ) cam (
        .clk(clk),
        .reset(reset),
        .set_en(grant),
        .set_value(sched.req_value),
        .clr_en(pop),
        .test_value(sched.req_value),
        .hit(hit)
    );
    cci_mpf_prim_semaphore_sched_fifo #(
        .N_ENTRIES(N_ENTRIES),
        .N_VALUE_BITS(N_VALUE_BITS)
    ) fifo (
        .clk(clk),
        .reset(reset),
        .push(grant),
        .push_value(sched.req_value),
        .pop(pop),
        .head(sched.cmpl_value),
        .count(n_inflight)
    );
`ifdef CCI_MPF_SEMAPHORE_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) stat_conflict_cycles <= '0;
        else if (conflict_stall && stat_conflict_cycles != '1) stat_conflict_cycles <= stat_conflict_cycles + 1'b1;
    end
`else
    assign stat_conflict_cycles = '0;
`endif
endmodule

// File: tb/tb_cci_mpf_prim_semaphore_sched.sv
// tb_cci_mpf_prim_semaphore_sched: directed and random checks against a queue-based reference model
module tb_cci_mpf_prim_semaphore_sched;
    localparam int N = 16;
    localparam int VB = 10;
    localparam int CW = $clog2(N) + 1;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rdy;
    logic conflict_stall;
    logic [CW-1:0] n_inflight;
    logic err_underflow;
    logic [31:0] stat_conflict_cycles;
    always #5 clk = ~clk;
    cci_mpf_prim_semaphore_sched_if #(.N_VALUE_BITS(VB)) bus ();
    cci_mpf_prim_semaphore_sched #(.N_ENTRIES(N), .N_VALUE_BITS(VB)) dut (
        .clk(clk),
        .reset(reset),
        .sched(bus),
        .rdy(rdy),
        .conflict_stall(conflict_stall),
        .n_inflight(n_inflight),
        .err_underflow(err_underflow),
        .stat_conflict_cycles(stat_conflict_cycles)
    );
    int n_assert = 0;
    int n_fail = 0;
    int q[$];
    bit drain_m = 0;
    bit rdy_m = 0;
    bit err_m = 0;
    longint stat_m = 0;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic bit in_q(input int v);
        foreach (q[i]) if (q[i] == v) return 1'b1;
        return 1'b0;
    endfunction
    // Model: in-flight tags are a queue; readiness derived from occupancy, membership and flush state.
    task automatic step(input bit v, input int val, input bit c, input bit f);
        bit full_m, hit_m, exp_ready, exp_stall;
        bus.req_valid = v;
        bus.req_value = VB'(val);
        bus.cmpl_en = c;
        bus.flush_req = f;
        @(negedge clk);
        full_m = q.size() >= N;
        hit_m = in_q(val);
        exp_ready = rdy_m && !drain_m && !full_m && !hit_m;
        exp_stall = v && rdy_m && !drain_m && !full_m && hit_m;
        chk("rdy", rdy, rdy_m);
        chk("req_ready", bus.req_ready, exp_ready);
        chk("conflict_stall", conflict_stall, exp_stall);
        chk("n_inflight", n_inflight, q.size());
        chk("flush_done", bus.flush_done, drain_m && q.size() == 0);
        chk("err_underflow", err_underflow, err_m);
        chk("stat", stat_conflict_cycles, stat_m);
        if (q.size() > 0) chk("cmpl_value", bus.cmpl_value, q[0]);
        if (drain_m && q.size() == 0) drain_m = 0;
        else if (!drain_m && f) drain_m = 1;
        if (c) begin
            if (q.size() > 0) void'(q.pop_front());
            else err_m = 1;
        end
        if (v && exp_ready) q.push_back(val);
`ifdef CCI_MPF_SEMAPHORE_SCHED_STATS_EN
        if (exp_stall && stat_m < 64'hFFFF_FFFF) stat_m++;
`endif
        rdy_m = 1;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset = 1;
        bus.req_valid = 0;
        bus.req_value = '0;
        bus.cmpl_en = 0;
        bus.flush_req = 0;
        @(posedge clk);
        @(negedge clk);
        q.delete();
        drain_m = 0;
        rdy_m = 0;
        err_m = 0;
        stat_m = 0;
        chk("rst_rdy", rdy, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_n_inflight", n_inflight, 0);
        chk("rst_flush_done", bus.flush_done, 0);
        chk("rst_err", err_underflow, 0);
        chk("rst_stat", stat_conflict_cycles, 0);
        chk("rst_stall", conflict_stall, 0);
        @(posedge clk);
        #1;
        reset = 0;
    endtask
    initial begin
        do_reset();
        step(0, 0, 0, 0);
        step(1, 'h010, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 'h010, 0, 0);
        step(1, 'h010, 1, 0);
        step(1, 'h010, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < N; i++) step(1, 'h100 + i, 0, 0);
        chk("full_count", n_inflight, N);
        step(1, 'h200, 0, 0);
        step(1, 'h200, 1, 0);
        step(1, 'h200, 0, 0);
        for (int i = 0; i < N; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 'h020 + i, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 'h040, 1, 0);
        step(1, 'h040, 0, 0);
        step(1, 'h040, 0, 0);
        step(1, 'h050, 0, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 'h060 + i, 0, 0);
        step(1, 'h070, 1, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 'h080 + i, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 'h080 + i, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 'h080, 0, 0);
        step(0, 0, 0, 0);
`ifdef CCI_MPF_SEMAPHORE_SCHED_STATS_EN
        chk("stat_seven", stat_conflict_cycles, 7);
`else
        chk("stat_zero", stat_conflict_cycles, 0);
`endif
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 400; i++) begin
            bit rv, rc, rf;
            int val;
            rv = 1'($urandom % 2);
            val = int'($urandom % 8);
            rc = (q.size() > 0) ? ($urandom % 3 == 0) : ($urandom % 50 == 0);
            rf = ($urandom % 40 == 0);
            step(rv, val, rc, rf);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/cci_mpf_prim_semaphore_sched.md
# cci_mpf_prim_semaphore_sched

Issue scheduler for a round-robin semaphore CAM: admits requests tagged with a value only when no in-flight request holds the same value, and never lets more than N_ENTRIES requests be in flight. In-flight values are retired strictly in order on completion, which guarantees the CAM's slot-reuse rule. It sits in front of MPF ordering and hazard logic, for example write-after-write address conflicts, between the request source and the downstream channel.

## Interface
- N_ENTRIES, 16: maximum in-flight requests; power of 2, ≥2; also the CAM depth and the retire FIFO depth.
- N_VALUE_BITS, 10: width of the tag value (e.g. hashed address).
- clk  in  1  single clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- rdy  out  1  0 while reset is high; 1 from the first cycle after reset deasserts.
- req_valid  in  1  request present; req_value must stay stable while req_valid=1 and no grant has occurred.
- req_value  in  N_VALUE_BITS  request tag.
- req_ready  out  1  grant qualifier; a grant occurs when req_valid && req_ready.
- cmpl_en  in  1  oldest in-flight request completed; at most one per cycle.
- cmpl_value  out  N_VALUE_BITS  tag of the oldest in-flight entry (head of FIFO); valid when n_inflight>0.
- flush_req  in  1  one-cycle pulse; drain all in-flight requests.
- flush_done  out  1  one-cycle pulse when the drain completes.
- conflict_stall  out  1  req_valid && rdy && state==RUN && !full && tag hit.
- n_inflight  out  $clog2(N_ENTRIES)+1  registered count of in-flight requests.
- err_underflow  out  1  sticky; set by cmpl_en while n_inflight==0; cleared only by reset.
- stat_conflict_cycles  out  32  stall counter (see Configuration).

## Operation
- Tag hit: combinational CAM test of req_value against valid entries (T0 result).
- req_ready = rdy && state==RUN && n_inflight<N_ENTRIES && !hit. All terms except hit are registered.
- On grant:
  - CAM set(req_value).
  - Push req_value to the retire FIFO.
  - n_inflight+1.
- On cmpl_en with n_inflight>0:
  - Pop the FIFO head.
  - CAM clear(head value).
  - n_inflight-1.
- Simultaneous grant and completion: n_inflight is unchanged; the FIFO pushes and pops in the same cycle.
- FSM states: RUN, DRAIN.
  - RUN→DRAIN on flush_req. A grant in the same cycle as flush_req is still allowed.
  - In DRAIN, req_ready=0.
  - DRAIN→RUN when n_inflight==0, with flush_done pulsed on that transition cycle.
  - flush_req received in DRAIN is ignored.
  - flush_req received with n_inflight==0 gives DRAIN for one cycle, then flush_done.
- Underflow (cmpl_en with empty FIFO): no pop, no clear, count stays 0, err_underflow set.

## Timing
- Reset (any cycle, including mid-drain): state=RUN, n_inflight=0, FIFO empty, all CAM entries invalid, flush_done=0, err_underflow=0, stat_conflict_cycles=0, rdy=0, req_ready=0, conflict_stall=0.
- Set and clear take effect at the next clock edge.
- A request with the same tag as one granted in cycle N sees the hit from cycle N+1, so back-to-back duplicates stall.
- Completion that frees a tag in cycle N: a stalled request with that tag is granted no earlier than cycle N+1.
- Full condition: a completion in cycle N allows a grant at the earliest in N+1.
- Grant-to-clear minimum latency is 1 cycle: a completion is legal the cycle after the grant.
- FIFO and CAM pointers wrap modulo N_ENTRIES.

## Configuration
- CCI_MPF_SEMAPHORE_SCHED_STATS_EN defined:
  - stat_conflict_cycles increments on every cycle with conflict_stall=1.
  - Saturates at 2^32-1.
- Not defined: stat_conflict_cycles is constant 0 and no counter logic is built.

## Structure
- Package cci_mpf_prim_semaphore_sched_pkg contains:
  - t_sched_state enum {RUN, DRAIN}.
  - Count typedef parameterized by N_ENTRIES.
  - Counter width constant = 32.
- Instantiates cci_mpf_prim_semaphore_cam with the same N_ENTRIES and N_VALUE_BITS.
- One new sub-module, cci_mpf_prim_semaphore_sched_fifo:
  - In-order value ring buffer holding N_ENTRIES entries.
  - Exposes head, count, push and pop.
- The FSM and the glue logic stay in the top level.

## Test plan
- Grant A=0x010 in cycle N, request A again in N+1 → req_ready=0 and conflict_stall=1 until a cmpl_en (head 0x010) in cycle M; grant in M+1.
- Issue 16 distinct tags with N_ENTRIES=16 → n_inflight=16, 17th request req_ready=0; a cmpl_en frees a slot and the 17th is granted the next cycle; cmpl_value order is 0..15.
- flush_req with 3 in flight, then complete one per cycle → req_ready=0 throughout; flush_done pulses once on the cycle n_inflight reaches 0; the next cycle is RUN.
- Grant and cmpl_en in the same cycle at n_inflight=5 → n_inflight stays 5 and the FIFO head advances.
- cmpl_en at n_inflight=0 → err_underflow=1 (sticky), n_inflight stays 0; reset clears it.
- Reset asserted mid-DRAIN with 4 in flight → after reset: RUN, n_inflight=0, the previously in-flight tags no longer hit; with the macro defined, a 7-cycle conflict stall yields stat_conflict_cycles=7.
